// File: rtl/centisecond_stopwatch_pkg.sv
// Shared definitions for the centisecond stopwatch: FSM states, BCD sizing
// and the per-digit maximum values of the MM:SS.CC chain.
package centisecond_stopwatch_pkg;

    localparam int BCD_W  = 4;
    localparam int DIGITS = 6;

    // Digit maxima, least significant digit first: cs_o, cs_t, sec_o, sec_t, min_o, min_t
    localparam logic [DIGITS*BCD_W-1:0] DIGIT_MAX = 24'h995999;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

endpackage

// File: rtl/centisecond_stopwatch_bcd_digit_counter.sv
// One BCD digit of the stopwatch chain; rolls over after MAX and reports a
// carry in the same cycle so a single tick ripples through every digit.
module bcd_digit_counter
    import centisecond_stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic [BCD_W-1:0] r_digit;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_digit <= '0;
        end else if (inc) begin
            r_digit <= (r_digit == MAX) ? '0 : r_digit + BCD_W'(1);
        end
    end

    assign digit = r_digit;
    assign carry = inc && (r_digit == MAX);

endmodule

// File: rtl/centisecond_stopwatch.sv
// MM:SS.CC stopwatch: run/pause/idle control, six chained BCD digits with a
// configurable minute wrap, and a lap register that can freeze the display.
module centisecond_stopwatch
    import centisecond_stopwatch_pkg::*;
#(
    parameter int WRAP_MINUTES = 60
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    start_stop,
    input  logic                    clear,
    input  logic                    lap,
    output logic [DIGITS*BCD_W-1:0] disp_digits,
    output logic                    running,
    output logic                    frozen,
    output logic                    wrap_pulse
);

    state_t                    r_state;
    logic                      r_frozen;
    logic                      r_running;
    logic                      r_wrap;
    logic [DIGITS*BCD_W-1:0]   r_held;
    logic [DIGITS*BCD_W-1:0]   r_disp;

    logic [DIGITS*BCD_W-1:0]   w_live;
    logic [DIGITS:0]           w_chain;
    logic [6:0]                w_minutes;
    logic                      w_count;
    logic                      w_at_last;
    logic                      w_wrap;
    logic                      w_clr_live;

    // Only the registered state decides counting, so a tick alongside the
    // start_stop that leaves RUNNING counts and one that enters it does not.
    assign w_count    = tick && (r_state == ST_RUNNING) && !clear;
    assign w_chain[0] = w_count;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_counter #(
            .MAX(DIGIT_MAX[g*BCD_W +: BCD_W])
        ) u_digit (
            .clock(clock),
            .reset(reset),
            .clr  (w_clr_live),
            .inc  (w_chain[g]),
            .digit(w_live[g*BCD_W +: BCD_W]),
            .carry(w_chain[g+1])
        );
    end

    assign w_minutes = 7'(w_live[23:20]) * 7'd10 + 7'(w_live[19:16]);
    assign w_at_last = (w_minutes == 7'(WRAP_MINUTES - 1)) && (w_live[15:0] == 16'h5999);

    // A carry out of min_t is also a rollover to zero, even though legal
    // WRAP_MINUTES values always wrap before it can happen.
    assign w_wrap     = (w_count && w_at_last) || w_chain[DIGITS];
    assign w_clr_live = clear || w_wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_frozen  <= 1'b0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            r_held    <= '0;
            r_disp    <= '0;
        end else begin
            r_wrap <= w_wrap;
            r_disp <= clear ? '0 : (r_frozen ? r_held : w_live);
            if (clear) begin
                r_state   <= ST_IDLE;
                r_frozen  <= 1'b0;
                r_running <= 1'b0;
            end else if (start_stop) begin
                case (r_state)
                    ST_IDLE, ST_PAUSED: begin
                        r_state   <= ST_RUNNING;
                        r_running <= 1'b1;
                    end
                    ST_RUNNING: begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end else if (lap) begin
                if (r_state == ST_RUNNING) begin
                    if (!r_frozen) begin
                        r_held <= w_live;
                    end
                    r_frozen <= !r_frozen;
                end else if (r_state == ST_PAUSED) begin
                    r_frozen <= 1'b0;
                end
            end
        end
    end

    assign disp_digits = r_disp;
    assign running     = r_running;
    assign frozen      = r_frozen;
    assign wrap_pulse  = r_wrap;

endmodule

// File: tb/tb_centisecond_stopwatch.sv
// Self-checking bench for centisecond_stopwatch: directed scenarios followed by
// random control traffic, all checked against a total-centiseconds model.
module tb_centisecond_stopwatch;

    localparam int WRAP   = 2;
    localparam int PERIOD = WRAP * 6000;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic        startStop;
    logic        clearIn;
    logic        lapIn;
    logic [23:0] dispDigits;
    logic        running;
    logic        frozen;
    logic        wrapPulse;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: time as plain centisecond counts, state 0=idle 1=run 2=pause
    int mLive   = 0;
    int mHeld   = 0;
    int mDisp   = 0;
    int mState  = 0;
    bit mFrozen = 0;
    bit mWrap   = 0;

    centisecond_stopwatch #(.WRAP_MINUTES(WRAP)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .start_stop (startStop),
        .clear      (clearIn),
        .lap        (lapIn),
        .disp_digits(dispDigits),
        .running    (running),
        .frozen     (frozen),
        .wrap_pulse (wrapPulse)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] toBcd(input int t);
        int m;
        int s;
        int c;
        m = t / 6000;
        s = (t / 100) % 60;
        c = t % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic modelStep(input bit rst, input bit tk, input bit ss, input bit clr, input bit lp);
        int  oldLive;
        bit  cnt;
        if (rst) begin
            mLive = 0; mHeld = 0; mDisp = 0; mState = 0; mFrozen = 0; mWrap = 0;
            return;
        end
        oldLive = mLive;
        mDisp   = clr ? 0 : (mFrozen ? mHeld : mLive);
        cnt     = tk && (mState == 1) && !clr;
        mWrap   = cnt && (mLive == PERIOD - 1);
        if (clr) mLive = 0;
        else if (cnt) mLive = (mLive + 1) % PERIOD;
        if (clr) begin
            mState = 0; mFrozen = 0;
        end else if (ss) begin
            mState = (mState == 1) ? 2 : 1;
        end else if (lp) begin
            if (mState == 1) begin
                if (!mFrozen) mHeld = oldLive;
                mFrozen = !mFrozen;
            end else if (mState == 2) begin
                mFrozen = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [23:0] expDisp;
        expDisp = toBcd(mDisp);
        compared++;
        assert (dispDigits === expDisp) else begin
            mismatched++;
            $error("[TB] FAIL %s disp_digits: got %h expected %h", tag, dispDigits, expDisp);
        end
        compared++;
        assert (running === (mState == 1)) else begin
            mismatched++;
            $error("[TB] FAIL %s running: got %b expected %b", tag, running, (mState == 1));
        end
        compared++;
        assert (frozen === mFrozen) else begin
            mismatched++;
            $error("[TB] FAIL %s frozen: got %b expected %b", tag, frozen, mFrozen);
        end
        compared++;
        assert (wrapPulse === mWrap) else begin
            mismatched++;
            $error("[TB] FAIL %s wrap_pulse: got %b expected %b", tag, wrapPulse, mWrap);
        end
    endtask

    task automatic checkDisp(input string tag, input logic [23:0] expDisp);
        compared++;
        assert (dispDigits === expDisp) else begin
            mismatched++;
            $error("[TB] FAIL %s directed disp_digits: got %h expected %h", tag, dispDigits, expDisp);
        end
    endtask

    task automatic checkBit(input string tag, input logic got, input logic expBit);
        compared++;
        assert (got === expBit) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %b expected %b", tag, got, expBit);
        end
    endtask

    // One clock: drive inputs, clock the DUT and model together, then check
    task automatic applyStimulus(input bit rst, input bit tk, input bit ss, input bit clr,
                                 input bit lp, input string tag);
        reset = rst; tick = tk; startStop = ss; clearIn = clr; lapIn = lp;
        @(posedge clock);
        modelStep(rst, tk, ss, clr, lp);
        #1;
        checkOutput(tag);
    endtask

    task automatic runTicks(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, tag);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; startStop = 1'b0; clearIn = 1'b0; lapIn = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, "reset");
        applyStimulus(1, 1, 1, 0, 1, "reset_busy_inputs");
        checkDisp("reset", 24'h000000);

        // Basic count: 150 ticks
        applyStimulus(0, 0, 1, 0, 0, "start");
        runTicks(150, "count150");
        applyStimulus(0, 0, 0, 0, 0, "idle150");
        checkDisp("count150", 24'h000150);
        checkBit("running_after_150", running, 1'b1);

        // Carry through four lower digits at 00:59.99
        runTicks(5999 - 150, "to_59_99");
        applyStimulus(0, 0, 0, 0, 0, "idle_59_99");
        checkDisp("at_00_59_99", 24'h005999);
        applyStimulus(0, 1, 0, 0, 0, "carry_tick");
        applyStimulus(0, 0, 0, 0, 0, "idle_carry");
        checkDisp("carry_01_00_00", 24'h010000);

        // Wrap at (WRAP-1):59.99
        runTicks(PERIOD - 6000 - 1, "to_wrap");
        applyStimulus(0, 0, 0, 0, 0, "idle_prewrap");
        checkDisp("prewrap", 24'h015999);
        applyStimulus(0, 1, 0, 0, 0, "wrap_tick");
        checkBit("wrap_pulse_high", wrapPulse, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, "after_wrap");
        checkBit("wrap_pulse_low", wrapPulse, 1'b0);
        checkBit("running_after_wrap", running, 1'b1);
        checkDisp("wrapped_zero", 24'h000000);

        // Pause holds digits; resume tick on the same cycle is not counted
        applyStimulus(0, 0, 0, 1, 0, "clear_pause");
        applyStimulus(0, 1, 1, 0, 0, "start_with_tick");
        runTicks(37, "to_37");
        applyStimulus(0, 0, 1, 0, 0, "pause");
        runTicks(20, "paused_ticks");
        applyStimulus(0, 0, 0, 0, 0, "idle_paused");
        checkDisp("paused_37", 24'h000037);
        checkBit("running_paused", running, 1'b0);
        applyStimulus(0, 1, 1, 0, 0, "resume_with_tick");
        applyStimulus(0, 0, 0, 0, 0, "idle_resume");
        applyStimulus(0, 0, 0, 0, 0, "idle_resume2");
        checkDisp("resume_tick_dropped", 24'h000037);
        applyStimulus(0, 1, 1, 0, 0, "pause_with_tick");
        applyStimulus(0, 0, 0, 0, 0, "idle_pause2");
        checkDisp("leave_tick_counted", 24'h000038);

        // Lap freeze and release
        applyStimulus(0, 0, 0, 1, 0, "clear_lap");
        applyStimulus(0, 0, 1, 0, 0, "start_lap");
        runTicks(100, "to_100");
        applyStimulus(0, 0, 0, 0, 1, "lap_on");
        runTicks(50, "frozen_ticks");
        applyStimulus(0, 0, 0, 0, 0, "idle_frozen");
        checkDisp("frozen_100", 24'h000100);
        checkBit("frozen_high", frozen, 1'b1);
        applyStimulus(0, 0, 0, 0, 1, "lap_off");
        applyStimulus(0, 0, 0, 0, 0, "idle_unfrozen");
        checkDisp("unfrozen_150", 24'h000150);

        // Clear with start_stop and tick while frozen, then reset mid-run
        applyStimulus(0, 1, 0, 0, 1, "lap_again");
        runTicks(10, "frozen_again");
        applyStimulus(0, 1, 1, 1, 0, "clear_ss_tick");
        checkDisp("clear_zero", 24'h000000);
        checkBit("clear_running", running, 1'b0);
        checkBit("clear_frozen", frozen, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, "restart");
        runTicks(77, "run_before_reset");
        applyStimulus(0, 0, 0, 0, 1, "lap_before_reset");
        applyStimulus(1, 1, 0, 0, 0, "midrun_reset");
        checkDisp("reset_zero", 24'h000000);
        checkBit("reset_running", running, 1'b0);

        // Random control traffic against the model
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(599) == 0), ($urandom_range(3) != 0),
                          ($urandom_range(39) == 0), ($urandom_range(299) == 0),
                          ($urandom_range(24) == 0), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
